// File: rtl/mux2_arbiter.sv
// Two-requester arbiter driving a registered 2:1 mux.
// Round-robin tie break on simultaneous requests; release hands off directly.
// Optional macro MUX2_ARB_PREEMPT_EN adds a hold counter that forces a handoff
// after MAX_HOLD consecutive grant cycles while the other side is waiting.
module mux2_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             grant0,
  output logic             grant1,
  output logic             s,
  output logic [WIDTH-1:0] o,
  output logic             o_valid
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  // Out-of-range hold limits are rejected at elaboration.
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mux2_arbiter: MAX_HOLD must be in 1..255");
  end

  logic [1:0] state, state_nxt;
  logic       last;     // 1 = requester 1 was served most recently
  logic       entering; // moving into a grant state this cycle
  logic       preempt;  // owner has used up its hold window

`ifdef MUX2_ARB_PREEMPT_EN
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD - 1);
  logic [7:0] hold;

  assign preempt = (hold == HOLD_MAX);

  // Hold counter: cleared on grant entry, saturates at the window limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hold <= 8'd0;
    else if (entering)
      hold <= 8'd0;
    else if (state != IDLE && hold != HOLD_MAX)
      hold <= hold + 8'd1;
  end
`else
  // Without the counter, an owner keeps the mux until it drops its request.
  assign preempt = 1'b0;
`endif

  assign grant0   = (state == GNT0);
  assign grant1   = (state == GNT1);
  assign entering = (state_nxt != state) && (state_nxt != IDLE);

  // Next-state arbitration; preemption only matters when the other side waits.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 && (!req1 || last)) state_nxt = GNT0;
        else if (req1)               state_nxt = GNT1;
      end
      GNT0: begin
        if (!req0)              state_nxt = req1 ? GNT1 : IDLE;
        else if (preempt && req1) state_nxt = GNT1;
      end
      GNT1: begin
        if (!req1)              state_nxt = req0 ? GNT0 : IDLE;
        else if (preempt && req0) state_nxt = GNT0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, last-served flag and select update on grant entry; s holds in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      s     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (entering) begin
        last <= (state_nxt == GNT1);
        s    <= (state_nxt == GNT1);
      end
    end
  end

  // Registered mux output; valid only while the owner still requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o       <= '0;
      o_valid <= 1'b0;
    end else begin
      o       <= s ? b : a;
      o_valid <= (grant0 & req0) | (grant1 & req1);
    end
  end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed bench for mux2_arbiter: per-step expectations go through a
// scoreboard queue and are compared one edge later; a random phase checks
// the grant/valid invariants.
module tb_mux2_arbiter;

`ifdef MUX2_ARB_PREEMPT_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  typedef struct packed {
    logic       g0;
    logic       g1;
    logic       s;
    logic [7:0] o;
    logic       ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] a = 8'h00, b = 8'h00;
  logic       grant0, grant1, s, o_valid;
  logic [7:0] o;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  mux2_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .a(a), .b(b),
    .grant0(grant0), .grant1(grant1), .s(s), .o(o), .o_valid(o_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected post-edge outputs,
  // then pop and compare after the edge.
  task automatic step(input string tag, input logic r0, input logic r1,
                      input logic [7:0] av, input logic [7:0] bv,
                      input logic e0, input logic e1, input logic es,
                      input logic [7:0] eo, input logic eov);
    exp_t e;
    req0 = r0; req1 = r1; a = av; b = bv;
    sb.push_back('{g0: e0, g1: e1, s: es, o: eo, ov: eov});
    @(posedge clk); #1;
    e = sb.pop_front();
    check({tag, ".grant0"},  32'(grant0),  32'(e.g0));
    check({tag, ".grant1"},  32'(grant1),  32'(e.g1));
    check({tag, ".s"},       32'(s),       32'(e.s));
    check({tag, ".o"},       32'(o),       32'(e.o));
    check({tag, ".o_valid"}, 32'(o_valid), 32'(e.ov));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".grant0"},  32'(grant0),  32'd0);
    check({tag, ".grant1"},  32'(grant1),  32'd0);
    check({tag, ".s"},       32'(s),       32'd0);
    check({tag, ".o"},       32'(o),       32'd0);
    check({tag, ".o_valid"}, 32'(o_valid), 32'd0);
  endtask

  initial begin
    // Reset state without any clock edge needed.
    #1;
    check_reset_state("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single requester 0: grant after 1 edge, valid data after 2.
    step("r0_e1", 1, 0, 8'h3C, 8'hA5, 1, 0, 0, 8'h3C, 0);
    step("r0_e2", 1, 0, 8'h3C, 8'hA5, 1, 0, 0, 8'h3C, 1);
    step("r0_rel", 0, 0, 8'h3C, 8'hA5, 0, 0, 0, 8'h3C, 0);

    // Fresh reset, then a tie: requester 0 wins first.
    rst = 1'b1; #1;
    check_reset_state("reset2");
    rst = 1'b0;
    step("tie_e1", 1, 1, 8'h11, 8'h22, 1, 0, 0, 8'h11, 0);
    step("tie_e2", 1, 1, 8'h11, 8'h22, 1, 0, 0, 8'h11, 1);
    // Owner releases: direct handoff, no IDLE bubble.
    step("hand_e1", 0, 1, 8'h11, 8'h22, 0, 1, 1, 8'h11, 0);
    step("hand_e2", 0, 1, 8'h11, 8'h22, 0, 1, 1, 8'h22, 1);

    // Requester 1 alone keeps the grant continuously.
    for (int i = 0; i < 10; i++) begin
      logic [7:0] bv;
      bv = 8'h40 + 8'(i);
      step($sformatf("solo1_%0d", i), 0, 1, 8'h11, bv, 0, 1, 1, bv, 1);
    end

    // Asynchronous reset between edges drops the grant at once.
    #2 rst = 1'b1;
    #1;
    check_reset_state("midrst");
    rst = 1'b0;

    // Both requesting after reset: GNT0, then preemption if enabled.
    step("pre_e1", 1, 1, 8'h55, 8'h66, 1, 0, 0, 8'h55, 0);
    for (int i = 2; i <= 4; i++)
      step($sformatf("pre_e%0d", i), 1, 1, 8'h55, 8'h66, 1, 0, 0, 8'h55, 1);
    step("pre_e5", 1, 1, 8'h55, 8'h66, !PE, PE, PE, 8'h55, 1);
    step("pre_e6", 1, 1, 8'h55, 8'h66, !PE, PE, PE, PE ? 8'h66 : 8'h55, 1);
    step("pre_rel", 0, 0, 8'h55, 8'h66, 0, 0, PE, PE ? 8'h66 : 8'h55, 0);

    // Tie from IDLE goes to the requester not served last.
    step("rr_e1", 1, 1, 8'h55, 8'h66, PE, !PE, !PE, PE ? 8'h66 : 8'h55, 0);
    step("rr_e2", 1, 1, 8'h55, 8'h66, PE, !PE, !PE, PE ? 8'h55 : 8'h66, 1);
    step("rr_rel", 0, 0, 8'h55, 8'h66, 0, 0, !PE, PE ? 8'h55 : 8'h66, 0);

    // Random request patterns: grant exclusivity and no valid in IDLE.
    for (int i = 0; i < 400; i++) begin
      req0 = 1'($urandom_range(0, 1));
      req1 = 1'($urandom_range(0, 1));
      a    = 8'($urandom);
      b    = 8'($urandom);
      @(posedge clk); #1;
      check("rand.excl", 32'(grant0 & grant1), 32'd0);
      check("rand.idle_valid", 32'(o_valid & ~grant0 & ~grant1), 32'd0);
    end

    check("sb.empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux2_arbiter.md
MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data width of each requester path and of o.
REQ-002 Parameter MAX_HOLD, default 4, maximum consecutive grant cycles while the other requester waits (legal range 1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0  input  1  requester 0 asks for / holds the shared mux.
REQ-006 req1  input  1  requester 1 asks for / holds the shared mux.
REQ-007 a  input  WIDTH  requester 0 data (mux input for s=0).
REQ-008 b  input  WIDTH  requester 1 data (mux input for s=1).
REQ-009 grant0  output  1  registered; requester 0 owns the mux.
REQ-010 grant1  output  1  registered; requester 1 owns the mux.
REQ-011 s  output  1  registered mux select; 0 = a, 1 = b.
REQ-012 o  output  WIDTH  registered mux output.
REQ-013 o_valid  output  1  registered; o holds granted requester data.

Function
REQ-014 States IDLE, GNT0, GNT1; grant0 = (state==GNT0), grant1 = (state==GNT1); never both high.
REQ-015 IDLE: req0 only -> GNT0; req1 only -> GNT1; both -> requester opposite to last-served flag; neither -> IDLE.
REQ-016 Last-served flag set to granted requester on every entry to GNT0/GNT1.
REQ-017 GNTx with reqx=1: remain, unless preemption per REQ-021 applies.
REQ-018 GNTx with reqx=0: other req=1 -> GNT(other) directly, no IDLE bubble; else -> IDLE.
REQ-019 s updates to 0 on entry to GNT0, 1 on entry to GNT1; holds last value in IDLE.
REQ-020 Each cycle: o <= (s ? b : a) and o_valid <= (grant0 & req0) | (grant1 & req1), sampled with current-cycle registers; latency request -> grant 1 cycle, grant -> o_valid 1 cycle.
REQ-021 Hold counter (8 bits): cleared on entry to any GNT state, increments each cycle in GNTx, saturates at MAX_HOLD-1; when at MAX_HOLD-1 and other req=1 -> GNT(other) regardless of reqx.
REQ-022 Hold counter has no effect while the other requester is idle; owner may hold indefinitely.
REQ-023 o in IDLE keeps tracking the mux at last s; o_valid=0.
REQ-024 Requester dropping req in same cycle as preemption: treated as release (REQ-018), same resulting state.

Reset
REQ-025 rst=1 forces immediately, without clk: state=IDLE, grant0=0, grant1=0, s=0, o=0, o_valid=0, hold counter=0, last-served flag=1 (requester 0 wins first tie).
REQ-026 rst asserted mid-grant drops grant within the same cycle; after release, arbitration restarts from IDLE per REQ-015.

Configuration
REQ-027 Macro MUX2_ARB_PREEMPT_EN: defined -> hold counter and REQ-021 preemption present; undefined -> counter absent, grant held until owner drops req, MAX_HOLD ignored.

Verification
REQ-028 Reset then req0=1, a=8'h3C, b=8'hA5 -> grant0=1 after 1 clk, o=8'h3C and o_valid=1 after 2 clk, s=0.
REQ-029 From reset, req0=req1=1 same cycle -> GNT0 first; req0 drops -> GNT1 next edge, s=1, o=b next edge after that.
REQ-030 With PREEMPT_EN, MAX_HOLD=4, req0 held, req1 raised -> grant0 high exactly 4 cycles from entry, then grant1; without macro grant0 stays high while req0=1.
REQ-031 req1 alone for 10 cycles, req0 idle -> grant1 uninterrupted 10 cycles, counter saturates, no toggling.
REQ-032 rst pulsed mid-GNT1 (between edges) -> grant1, o_valid, s, o go to 0 immediately; after release with req0=req1=1 -> GNT0.
REQ-033 Exhaustive req0/req1 sequence over all states -> grant0&grant1 never both 1, o_valid never 1 in IDLE.
